data_ram_arb: RTL and testbench
===============================

DATA_RAM_ARB -- requirements
Module: data_ram_arb

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL: mN_req_valid  in  1  port N request valid (N = 0, 1; port 0 = memory stage, port 1 = secondary requester).
REQ-004 SHALL: mN_req_ready  out  1  port N request accepted this cycle when high together with mN_req_valid.
REQ-005 SHALL: mN_we  in  1  port N 1 = write, 0 = read.
REQ-006 SHALL: mN_addr  in  32  port N byte address (bus32_t).
REQ-007 SHALL: mN_sel  in  4  port N byte-lane select; bit i enables byte i.
REQ-008 SHALL: mN_wdata  in  32  port N write data.
REQ-009 SHALL: mN_resp_valid  out  1  port N one-cycle response pulse, for both reads and writes.
REQ-010 SHALL: mN_rdata  out  32  port N read data; valid only while mN_resp_valid is high; 0 for writes.
REQ-011 SHALL: ram_en, ram_write_en, ram_read_en  out  1 each  RAM enable, write strobe and read strobe.
REQ-012 SHALL: ram_addr  out  32; ram_select  out  4; ram_wdata  out  32  RAM address, byte select and write data.
REQ-013 SHALL: ram_rdata  in  32  RAM read data; combinational from ram_addr while ram_en and ram_read_en are high.

Function
REQ-014 SHALL: implement an FSM with states IDLE, ACCESS and RESP.
REQ-015 SHALL: assert mN_req_ready only in IDLE or RESP, and only to the single granted port.
REQ-016 SHALL: on acceptance in cycle T, latch we/addr/sel/wdata and the grant, and enter ACCESS at T+1.
REQ-017 SHALL: in ACCESS, drive ram_en=1, ram_write_en=we, ram_read_en=!we and the latched fields; RAM write commits at end of T+1.
REQ-018 SHALL: at end of ACCESS, register ram_rdata (reads) or 0 (writes), and pulse the granted mN_resp_valid in RESP at T+2.
REQ-019 SHALL: from RESP, go to ACCESS if a new request is accepted that cycle, otherwise go to IDLE (peak throughput: one access per 2 cycles).
REQ-020 SHALL: outside ACCESS, hold ram_en, ram_write_en and ram_read_en at 0, and hold ram_addr, ram_select and ram_wdata at their last value.
REQ-021 SHALL: requesters hold valid and payload stable until ready; data_ram_arb does not check this, and a change before acceptance simply wins.
REQ-022 SHALL: grant a lone requester immediately; resolve simultaneous requests per REQ-027/028.
REQ-023 SHALL: never pulse both mN_resp_valid outputs in the same cycle, and never issue a response without a prior acceptance.
REQ-024 SHALL: forward addresses unmodified; any address wrap (addr[11:2]) is the RAM's responsibility.

Reset
REQ-025 SHALL: on rst, return to IDLE, clear both ready/resp_valid outputs, clear rdata to 0, clear ram_* outputs to 0, and set the round-robin pointer to port 0.
REQ-026 SHALL: on rst asserted mid-ACCESS or mid-RESP, drop the in-flight access with no response; a write strobe active in that cycle is suppressed.

Configuration
REQ-027 SHALL: with DATA_RAM_ARB_RR_EN defined, arbitrate round-robin: the last-granted port loses a tie and the pointer updates on each acceptance.
REQ-028 SHALL: with DATA_RAM_ARB_RR_EN undefined, use fixed priority with port 0 always winning ties; port 1 may starve.

Structure
REQ-029 SHALL: place dram_req_t (we, addr, sel, wdata) and the arbiter state enum in pipeline_types, and reuse bus32_t.
REQ-030 SHALL: put the 2-way grant selection in sub-module dram_arb_pick (inputs: valids, pointer; output: one-hot grant).
REQ-031 SHALL: not instantiate the RAM; connect to it externally through the ram_* ports.

Verification
REQ-032 SHALL: cover: m0 write addr=0x10, sel=4'b1111, wdata=0xDEADBEEF, then m0 read 0x10 -> read m0_resp_valid at accept+2 with m0_rdata=0xDEADBEEF.
REQ-033 SHALL: cover: m1 write addr=0x20, sel=4'b0010, wdata=0x0000AB00 over prior 0x11223344, then read -> m1_rdata=0x1122AB44.
REQ-034 SHALL: cover: m0 and m1 valid together for 4 accesses -> RR build grants 0,1,0,1; fixed-priority build grants 0,0,0,0 with m1_req_ready stuck at 0.
REQ-035 SHALL: cover: back-to-back m0 reads accepted in RESP -> one ram_en pulse every 2 cycles, resp_valid every 2 cycles.
REQ-036 SHALL: cover: rst asserted during ACCESS of m1 write 0x30=0x55 -> no m1_resp_valid, and a later read of 0x30 returns the old value.
REQ-037 SHALL: cover: idle bus for 10 cycles -> ram_en=0 throughout, both resp_valid=0.

Source files
------------

// File: rtl/pipeline_types.sv
// Shared pipeline types: bus word, data-RAM request record and arbiter state encoding.
package pipeline_types;

  typedef logic [31:0] bus32_t;

  typedef struct packed {
    logic       we;
    bus32_t     addr;
    logic [3:0] sel;
    bus32_t     wdata;
  } dram_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } dram_arb_state_t;

endpackage

// File: rtl/dram_arb_pick.sv
// Two-way grant selection: a lone requester wins outright, a tie goes to the port named by ptr.
module dram_arb_pick (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_ram_arb.sv
// Two-port arbiter in front of a single-port data RAM; one access per two cycles at peak.
// Define DATA_RAM_ARB_RR_EN for round-robin arbitration, otherwise port 0 has fixed priority.
//
// state  | meaning
// IDLE   | no access in flight, may accept a request
// ACCESS | RAM strobes driven from the latched request
// RESP   | response pulse to the granted port, may accept the next request
module data_ram_arb
  import pipeline_types::*;
(
  input  logic         clk,
  input  logic         rst,

  input  logic         m0_req_valid,
  output logic         m0_req_ready,
  input  logic         m0_we,
  input  bus32_t       m0_addr,
  input  logic [3:0]   m0_sel,
  input  bus32_t       m0_wdata,
  output logic         m0_resp_valid,
  output bus32_t       m0_rdata,

  input  logic         m1_req_valid,
  output logic         m1_req_ready,
  input  logic         m1_we,
  input  bus32_t       m1_addr,
  input  logic [3:0]   m1_sel,
  input  bus32_t       m1_wdata,
  output logic         m1_resp_valid,
  output bus32_t       m1_rdata,

  output logic         ram_en,
  output logic         ram_write_en,
  output logic         ram_read_en,
  output bus32_t       ram_addr,
  output logic [3:0]   ram_select,
  output bus32_t       ram_wdata,
  input  bus32_t       ram_rdata
);

  dram_arb_state_t state_q, state_d;
  dram_req_t       req_q, req_sel;
  logic            gnt_q;
  bus32_t          rdata_q;

  logic [1:0] valid, grant;
  logic       can_accept, accept, accept_port;
  logic       in_access, in_resp;

  assign valid = {m1_req_valid, m0_req_valid};

`ifdef DATA_RAM_ARB_RR_EN
  // ptr_q names the port that wins the next tie: the one not granted last.
  logic ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= ~accept_port;
    end
  end

  dram_arb_pick u_pick (
    .valid (valid),
    .ptr   (ptr_q),
    .grant (grant)
  );
`else
  dram_arb_pick u_pick (
    .valid (valid),
    .ptr   (1'b0),
    .grant (grant)
  );
`endif

  // Reset gates the outputs combinationally so a write strobe in the reset cycle never reaches the RAM.
  assign can_accept  = ((state_q == ARB_IDLE) || (state_q == ARB_RESP)) && !rst;
  assign accept      = can_accept && (grant != 2'b00);
  assign accept_port = grant[1];

  assign m0_req_ready = can_accept && grant[0];
  assign m1_req_ready = can_accept && grant[1];

  always_comb begin
    req_sel = '0;
    if (accept_port) begin
      req_sel.we    = m1_we;
      req_sel.addr  = m1_addr;
      req_sel.sel   = m1_sel;
      req_sel.wdata = m1_wdata;
    end else begin
      req_sel.we    = m0_we;
      req_sel.addr  = m0_addr;
      req_sel.sel   = m0_sel;
      req_sel.wdata = m0_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (accept) state_d = ARB_ACCESS;
      ARB_ACCESS: state_d = ARB_RESP;
      ARB_RESP:   state_d = accept ? ARB_ACCESS : ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      req_q   <= '0;
      gnt_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= req_sel;
        gnt_q <= accept_port;
      end
      if (state_q == ARB_ACCESS) begin
        rdata_q <= req_q.we ? '0 : ram_rdata;
      end
    end
  end

  assign in_access = (state_q == ARB_ACCESS) && !rst;
  assign in_resp   = (state_q == ARB_RESP) && !rst;

  assign ram_en       = in_access;
  assign ram_write_en = in_access && req_q.we;
  assign ram_read_en  = in_access && !req_q.we;
  assign ram_addr     = req_q.addr;
  assign ram_select   = req_q.sel;
  assign ram_wdata    = req_q.wdata;

  assign m0_resp_valid = in_resp && !gnt_q;
  assign m1_resp_valid = in_resp && gnt_q;
  assign m0_rdata      = m0_resp_valid ? rdata_q : '0;
  assign m1_rdata      = m1_resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_data_ram_arb.sv
// Bench for data_ram_arb: directed vector table, corner sequences and a randomized transaction model.
module tb_data_ram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld, we, rdy, rv;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  sel [2];
  logic [31:0] rdata [2];
  logic        ram_en, ram_write_en, ram_read_en;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_select;

  logic [31:0] ram_mem [1024];
  logic [31:0] ref_mem [1024];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_ram_arb dut (
    .clk           (clk),
    .rst           (rst),
    .m0_req_valid  (vld[0]),
    .m0_req_ready  (rdy[0]),
    .m0_we         (we[0]),
    .m0_addr       (addr[0]),
    .m0_sel        (sel[0]),
    .m0_wdata      (wdata[0]),
    .m0_resp_valid (rv[0]),
    .m0_rdata      (rdata[0]),
    .m1_req_valid  (vld[1]),
    .m1_req_ready  (rdy[1]),
    .m1_we         (we[1]),
    .m1_addr       (addr[1]),
    .m1_sel        (sel[1]),
    .m1_wdata      (wdata[1]),
    .m1_resp_valid (rv[1]),
    .m1_rdata      (rdata[1]),
    .ram_en        (ram_en),
    .ram_write_en  (ram_write_en),
    .ram_read_en   (ram_read_en),
    .ram_addr      (ram_addr),
    .ram_select    (ram_select),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  // External RAM: 1K words indexed by addr[11:2], combinational read, byte-masked write.
  always_comb ram_rdata = (ram_en && ram_read_en) ? ram_mem[ram_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (ram_en && ram_write_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_select[b]) ram_mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    vld = 2'b00;
    we  = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; wdata[p] = '0; sel[p] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) until port p is ready; caller is positioned #1 after a negedge.
  task automatic wait_ready(input int p, input string nm);
    int waited = 0;
    while (!rdy[p] && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    chk1({nm, " accept"}, rdy[p], 1'b1);
  endtask

  // One full transaction with exact latency: accept at T, ACCESS at T+1, response at T+2.
  task automatic do_txn(input int p, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp, input string nm);
    @(negedge clk);
    vld[p] = 1'b1; we[p] = w; addr[p] = a; sel[p] = s; wdata[p] = d;
    #1;
    wait_ready(p, nm);
    @(negedge clk);
    vld[p] = 1'b0;
    #1;
    chk1({nm, " ram_en"}, ram_en, 1'b1);
    chk1({nm, " ram_write_en"}, ram_write_en, w);
    chk1({nm, " ram_read_en"}, ram_read_en, !w);
    chk32({nm, " ram_addr"}, ram_addr, a);
    chk32({nm, " ram_select"}, {28'd0, ram_select}, {28'd0, s});
    @(negedge clk); #1;
    chk1({nm, " resp_valid"}, rv[p], 1'b1);
    chk1({nm, " other resp_valid"}, rv[1-p], 1'b0);
    chk1({nm, " ram_en in resp"}, ram_en, 1'b0);
    chk32({nm, " rdata"}, rdata[p], exp);
  endtask

  typedef struct {
    int          port;
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } rsp_t;

  vec_t vecs [8];
  rsp_t rq [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_grant [4];
    logic [1:0] clr, exp_rdy, exp_rv;
    logic [31:0] exp_dat, rdv;
    int busy_until, last_gnt, winner, waited, idx;
    rsp_t r;

    rst = 1'b1;
    idle_inputs();

    // Reset state, with both requesters asserting valid.
    repeat (3) @(negedge clk);
    vld = 2'b11;
    #1;
    chk32("reset ready", {30'd0, rdy}, 32'd0);
    chk32("reset resp_valid", {30'd0, rv}, 32'd0);
    chk32("reset m0_rdata", rdata[0], 32'd0);
    chk32("reset m1_rdata", rdata[1], 32'd0);
    chk32("reset ram strobes", {29'd0, ram_en, ram_write_en, ram_read_en}, 32'd0);
    chk32("reset ram_addr", ram_addr, 32'd0);
    chk32("reset ram_select", {28'd0, ram_select}, 32'd0);
    chk32("reset ram_wdata", ram_wdata, 32'd0);
    @(negedge clk);
    vld = 2'b00;
    rst = 1'b0;

    // Idle bus for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk1("idle ram_en", ram_en, 1'b0);
      chk32("idle resp_valid", {30'd0, rv}, 32'd0);
    end

    vecs[0] = '{0, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1, 1'b1, 32'h0000_0020, 4'b1111, 32'h1122_3344, 32'h0};
    vecs[3] = '{1, 1'b1, 32'h0000_0020, 4'b0010, 32'h0000_AB00, 32'h0};
    vecs[4] = '{1, 1'b0, 32'h0000_0020, 4'b1111, 32'h0,         32'h1122_AB44};
    vecs[5] = '{0, 1'b0, 32'h0000_0020, 4'b0001, 32'h0,         32'h1122_AB44};
    vecs[6] = '{0, 1'b0, 32'h0000_1020, 4'b1111, 32'h0,         32'h1122_AB44};
    vecs[7] = '{1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].port, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].exp,
             $sformatf("vec%0d", i));

    // Back-to-back m0 reads accepted in RESP.
    @(negedge clk);
    vld[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; sel[0] = 4'hF;
    #1;
    wait_ready(0, "b2b first");
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) vld[0] = 1'b0;
      #1;
      chk1($sformatf("b2b ram_en k=%0d", k), ram_en, (k % 2) == 1);
      chk1($sformatf("b2b resp_valid k=%0d", k), rv[0], (k % 2) == 0);
      if (k % 2 == 0) chk32($sformatf("b2b rdata k=%0d", k), rdata[0], 32'hDEAD_BEEF);
    end

    // Simultaneous requests from a fresh reset.
`ifdef DATA_RAM_ARB_RR_EN
    exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    do_reset();
    @(negedge clk);
    vld = 2'b11; we = 2'b00;
    addr[0] = 32'h40; addr[1] = 32'h44; sel[0] = 4'hF; sel[1] = 4'hF;
    #1;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (rdy == 2'b00 && waited < 20) begin
        @(negedge clk); #1;
        waited++;
      end
      chk32($sformatf("tie grant %0d", k), {30'd0, rdy}, {30'd0, exp_grant[k]});
      @(negedge clk);
      if (k == 3) vld = 2'b00;
      #1;
      chk32($sformatf("tie ready in access %0d", k), {30'd0, rdy}, 32'd0);
      @(negedge clk); #1;
      chk32($sformatf("tie resp %0d", k), {30'd0, rv}, {30'd0, exp_grant[k]});
    end

    // Reset during ACCESS of an m1 write drops it.
    do_txn(0, 1'b1, 32'h30, 4'hF, 32'h0000_0077, 32'h0, "rst pre-write");
    @(negedge clk);
    vld[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30; sel[1] = 4'hF; wdata[1] = 32'h55;
    #1;
    wait_ready(1, "rst victim");
    @(negedge clk);
    vld[1] = 1'b0;
    rst = 1'b1;
    #1;
    chk1("rst suppress ram_en", ram_en, 1'b0);
    chk1("rst suppress ram_write_en", ram_write_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk32("rst no resp", {30'd0, rv}, 32'd0);
      @(negedge clk);
    end
    do_txn(1, 1'b0, 32'h30, 4'hF, 32'h0, 32'h0000_0077, "rst post-read");

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram_mem[i];
    busy_until = 0;
    last_gnt   = 1;
    clr        = 2'b00;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      vld = vld & ~clr;
      clr = 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (!vld[p] && $urandom_range(0, 2) != 0) begin
          vld[p]   = 1'b1;
          we[p]    = 1'($urandom_range(0, 1));
          addr[p]  = ($urandom() & 32'h0000_003C) | (32'($urandom_range(0, 1)) << 12);
          sel[p]   = 4'($urandom_range(0, 15));
          wdata[p] = $urandom();
        end
      end
      #1;
      exp_rdy = 2'b00;
      if (c >= busy_until && vld != 2'b00) begin
`ifdef DATA_RAM_ARB_RR_EN
        winner = (vld == 2'b11) ? (last_gnt == 0 ? 1 : 0) : (vld[1] ? 1 : 0);
`else
        winner = vld[0] ? 0 : 1;
`endif
        exp_rdy[winner] = 1'b1;
      end
      chk32($sformatf("rand ready c=%0d", c), {30'd0, rdy}, {30'd0, exp_rdy});
      exp_rv  = 2'b00;
      exp_dat = 32'h0;
      if (rq.size() > 0 && rq[0].due == c) begin
        r = rq.pop_front();
        exp_rv[r.port] = 1'b1;
        exp_dat = r.data;
      end
      chk32($sformatf("rand resp_valid c=%0d", c), {30'd0, rv}, {30'd0, exp_rv});
      if (exp_rv != 2'b00)
        chk32($sformatf("rand rdata c=%0d", c), exp_rv[1] ? rdata[1] : rdata[0], exp_dat);
      if (exp_rdy != 2'b00) begin
        winner = exp_rdy[1] ? 1 : 0;
        idx = int'(addr[winner][11:2]);
        rdv = 32'h0;
        if (we[winner]) begin
          for (int b = 0; b < 4; b++)
            if (sel[winner][b]) ref_mem[idx][8*b +: 8] = wdata[winner][8*b +: 8];
        end else begin
          rdv = ref_mem[idx];
        end
        rq.push_back('{c + 2, winner, rdv});
        busy_until = c + 2;
        last_gnt = winner;
        clr[winner] = 1'b1;
      end
    end
    @(negedge clk);
    vld = 2'b00;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
